// File: rtl/div_hilo_unit.sv
// Iterative restoring divider with the HI/LO register pair for the MIPS core.
//
// A div/divu issued in Execute is latched in IDLE, one quotient bit is resolved
// per cycle in RUN (WIDTH cycles), and FIX applies sign correction and commits
// the quotient to LO and the remainder to HI. mthi/mtlo write HI/LO directly
// while the unit is idle.
//
// Ports:
//   clk        core clock, rising edge
//   rst        asynchronous active-high reset
//   StartDivE  div/divu issued in Execute this cycle
//   SignedE    1 = div (signed), 0 = divu
//   SrcAE      dividend (rs); also the mthi/mtlo data
//   SrcBE      divisor (rt)
//   WriteHiE   mthi: HI <= SrcAE (idle only)
//   WriteLoE   mtlo: LO <= SrcAE (idle only)
//   HiOut      current HI register
//   LoOut      current LO register
//   DivBusy    division in flight, stalls mfhi/mflo in Decode
//   DivDone    one-cycle pulse after HI/LO commit
module div_hilo_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StartDivE,
  input  logic             SignedE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             WriteHiE,
  input  logic             WriteLoE,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             DivBusy,
  output logic             DivDone
);

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CntMax   = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q, raw_a_q;
  logic             qneg_q, rneg_q, dbz_q;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    // Magnitudes only for signed division; divu uses the raw bit patterns.
    abs_a = SrcAE;
    abs_b = SrcBE;
    if (SignedE && SrcAE[WIDTH-1]) abs_a = -SrcAE;
    if (SignedE && SrcBE[WIDTH-1]) abs_b = -SrcBE;

    // Shifted partial remainder needs one extra bit: 2*rem + 1 can exceed WIDTH
    // bits. Since rem < divisor, bit WIDTH of the trial is exactly the borrow.
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, dvsr_q};
    quo_nxt = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    rem_nxt = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];

    quo_fix = qneg_q ? -quo_q : quo_q;
    rem_fix = rneg_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      raw_a_q <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (StartDivE) begin
            // Start wins over mthi/mtlo in the same cycle.
            state_q <= StRun;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= abs_a;
            dvsr_q  <= abs_b;
            raw_a_q <= SrcAE;
            qneg_q  <= SignedE & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
            rneg_q  <= SignedE & SrcAE[WIDTH-1];
            dbz_q   <= (SrcBE == '0);
          end else begin
            if (WriteHiE) hi_q <= SrcAE;
            if (WriteLoE) lo_q <= SrcAE;
          end
        end
        StRun: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          if (cnt_q != CntMax) cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIter) state_q <= StFix;
        end
        StFix: begin
          if (dbz_q) begin
            lo_q <= '1;
            hi_q <= raw_a_q;
          end else begin
            lo_q <= quo_fix;
            hi_q <= rem_fix;
          end
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign HiOut   = hi_q;
  assign LoOut   = lo_q;
  assign DivBusy = busy_q;
  assign DivDone = done_q;

endmodule

// File: tb/tb_div_hilo_unit.sv
// Directed bench for div_hilo_unit: reset state, signed/unsigned division,
// overflow and divide-by-zero corners, mthi/mtlo, ignored requests while busy,
// and asynchronous reset mid-division.
module tb_div_hilo_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StartDivE = 1'b0;
  logic        SignedE = 1'b0;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        WriteHiE = 1'b0;
  logic        WriteLoE = 1'b0;
  logic [31:0] HiOut, LoOut;
  logic        DivBusy, DivDone;

  int tests = 0;
  int fails = 0;

  div_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .StartDivE (StartDivE),
    .SignedE   (SignedE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .WriteHiE  (WriteHiE),
    .WriteLoE  (WriteLoE),
    .HiOut     (HiOut),
    .LoOut     (LoOut),
    .DivBusy   (DivBusy),
    .DivDone   (DivDone)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a division, watch it through 33 busy cycles, then check the commit.
  // extra_wr asserts mthi/mtlo alongside the start; inject fires a second
  // start plus mtlo in the middle of RUN. Both must be ignored.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_lo,
                        input logic [31:0] exp_hi, input logic extra_wr,
                        input logic inject);
    logic [31:0] old_hi, old_lo;
    int          bad;
    old_hi = HiOut;
    old_lo = LoOut;
    bad = 0;
    StartDivE = 1'b1;
    SignedE   = sgn;
    SrcAE     = a;
    SrcBE     = b;
    WriteHiE  = extra_wr;
    WriteLoE  = extra_wr;
    tick();
    StartDivE = 1'b0;
    WriteHiE  = 1'b0;
    WriteLoE  = 1'b0;
    SrcAE     = 32'h5555_5555;
    SrcBE     = 32'h0000_0003;
    check({tag, " busy@0"}, {31'd0, DivBusy}, 32'd1);
    for (int i = 1; i <= 32; i++) begin
      if (inject && i == 5) begin
        StartDivE = 1'b1;
        SignedE   = 1'b0;
        SrcAE     = 32'd1000;
        WriteLoE  = 1'b1;
      end
      tick();
      StartDivE = 1'b0;
      WriteLoE  = 1'b0;
      if (DivBusy !== 1'b1 || DivDone !== 1'b0 || HiOut !== old_hi || LoOut !== old_lo)
        bad++;
    end
    check({tag, " run-hold"}, bad, 32'd0);
    tick();
    check({tag, " busy@33"}, {31'd0, DivBusy}, 32'd0);
    check({tag, " done@33"}, {31'd0, DivDone}, 32'd1);
    check({tag, " LO"}, LoOut, exp_lo);
    check({tag, " HI"}, HiOut, exp_hi);
    tick();
    check({tag, " done@34"}, {31'd0, DivDone}, 32'd0);
  endtask

  initial begin
    #1;
    check("rst HI", HiOut, 32'd0);
    check("rst LO", LoOut, 32'd0);
    check("rst busy", {31'd0, DivBusy}, 32'd0);
    check("rst done", {31'd0, DivDone}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post-rst busy", {31'd0, DivBusy}, 32'd0);

    do_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    do_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    do_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    do_div("div dbz", 1'b1, 32'hFFFF_FFF6, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF6, 1'b0, 1'b0);
    do_div("divu dbz", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0);

    // mthi alone, then both in one cycle
    SrcAE    = 32'h0000_1234;
    WriteHiE = 1'b1;
    tick();
    WriteHiE = 1'b0;
    check("mthi HI", HiOut, 32'h0000_1234);
    check("mthi LO kept", LoOut, 32'hFFFF_FFFF);
    SrcAE    = 32'h0000_ABCD;
    WriteHiE = 1'b1;
    WriteLoE = 1'b1;
    tick();
    WriteHiE = 1'b0;
    WriteLoE = 1'b0;
    check("mthi+mtlo HI", HiOut, 32'h0000_ABCD);
    check("mthi+mtlo LO", LoOut, 32'h0000_ABCD);

    // start beats mthi/mtlo; mid-run start/mtlo ignored
    do_div("divu 20/6 prio", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b1, 1'b1);

    // async reset at cycle 10 of a division
    StartDivE = 1'b1;
    SignedE   = 1'b0;
    SrcAE     = 32'd50;
    SrcBE     = 32'd7;
    tick();
    StartDivE = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("pre-rst busy", {31'd0, DivBusy}, 32'd1);
    rst = 1'b1;
    #1;
    check("async rst HI", HiOut, 32'd0);
    check("async rst LO", LoOut, 32'd0);
    check("async rst busy", {31'd0, DivBusy}, 32'd0);
    check("async rst done", {31'd0, DivDone}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("after rst idle", {30'd0, DivBusy, DivDone}, 32'd0);
    check("after rst LO", LoOut, 32'd0);

    do_div("divu 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_hilo_unit.md
# div_hilo_unit

Iterative 32-bit divider and HI/LO register file for the pipelined MIPS core. It sits beside the Execute stage. It accepts `div`/`divu` and `mthi`/`mtlo` from Execute and holds HI/LO for `mfhi`/`mflo` reads in Decode. It drives `DivBusy`, which the hazard unit consumes to stall an `mfhi`/`mflo` in Decode until the quotient and remainder are committed.

## Interface
Parameters:
- WIDTH, 32, operand/HI/LO width
- CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
- clk  in  1  core clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- StartDivE  in  1  div/divu issued in Execute this cycle
- SignedE  in  1  1 = div (signed), 0 = divu
- SrcAE  in  WIDTH  dividend (rs)
- SrcBE  in  WIDTH  divisor (rt)
- WriteHiE  in  1  mthi in Execute; HI <= SrcAE
- WriteLoE  in  1  mtlo in Execute; LO <= SrcAE
- HiOut  out  WIDTH  current HI
- LoOut  out  WIDTH  current LO
- DivBusy  out  1  division in flight (to hazard unit)
- DivDone  out  1  one-cycle pulse after HI/LO commit

## Operation
- States: IDLE, RUN, FIX. Reset sets all of the following:
  - state=IDLE, counter=0
  - HI=0, LO=0
  - DivBusy=0, DivDone=0
  - all internal datapath registers = 0
- IDLE + StartDivE:
  - latch |SrcAE| and |SrcBE|; magnitudes are taken only when SignedE=1.
  - latch the quotient sign (SrcAE[31]^SrcBE[31]) and the remainder sign (SrcAE[31]), each gated by SignedE.
  - latch a divide-by-zero flag (SrcBE==0) and the raw SrcAE.
  - counter=0; go to RUN.
- RUN performs one restoring step per cycle on unsigned magnitudes:
  - shift {rem, quo} left by 1.
  - trial = rem − divisor, computed WIDTH+1 bits wide.
  - If there is no borrow: rem = trial, quo LSB = 1.
  - counter increments; after the WIDTH-th step go to FIX.
- FIX commits the result and returns to IDLE:
  - Divide-by-zero: LO = all-ones, HI = raw dividend, no sign correction, for both signed and unsigned.
  - Otherwise: LO = quotient, negated (two's complement) if the quotient sign is set; HI = remainder, negated if the remainder sign is set.
  - Overflow −2^31 / −1 falls out naturally: LO = 0x80000000, HI = 0.
- WriteHiE/WriteLoE:
  - Honoured only in IDLE with StartDivE=0. Both may be set in the same cycle.
  - Ignored in RUN/FIX; the hazard unit prevents this case.
- StartDivE:
  - Ignored in RUN/FIX; a division in flight is never restarted or aborted.
  - StartDivE has priority over WriteHiE/WriteLoE in the same IDLE cycle.
- HiOut/LoOut are direct register outputs. They hold old values throughout RUN and FIX and change only on the FIX→IDLE edge or an mthi/mtlo edge.
- DivBusy = registered (state != IDLE).

## Timing
- Edge 0 (StartDivE sampled): state→RUN, DivBusy→1.
- Edges 1..32: iterations 1..32; state→FIX on edge 32.
- Edge 33: HI/LO written, state→IDLE, DivBusy→0, DivDone→1.
- Edge 34: DivDone→0.
- DivBusy is high for exactly 33 cycles.
- A StartDivE on edge 33's cycle is impossible because state is FIX; the earliest back-to-back start is sampled at edge 34.
- mthi/mtlo: HiOut/LoOut update on the sampling edge (latency 1).
- Reset asserted mid-RUN: the division is abandoned immediately (asynchronously). HI, LO, DivBusy and DivDone are 0 while reset is high, and nothing is committed.
- Counter never wraps: it saturates and is cleared on entry to RUN.

## Test plan
- divu 100/7: DivBusy high for cycles 1..33. After edge 33, LO=14, HI=2, DivDone pulses once, HiOut/LoOut unchanged before edge 33.
- div −7/2 and 7/−2: LO=0xFFFFFFFD (−3) for both. HI=0xFFFFFFFF (−1) for the first, HI=1 for the second.
- Corner cases:
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - divu 0xFFFFFFFF / 1 → LO=0xFFFFFFFF, HI=0.
- Divide by zero:
  - div 0xFFFFFFF6 / 0 and divu 5 / 0 → LO=0xFFFFFFFF, HI=dividend, both after 33 cycles.
- mthi 0x1234 in IDLE: HiOut=0x1234 next cycle. StartDivE and a second StartDivE/mtlo during RUN are ignored, and the first result is committed unchanged.
- Reset pulse at cycle 10 of a division: outputs go to 0 immediately, state is IDLE. A fresh divu 9/3 afterwards yields LO=3, HI=0.
